multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_defs_pkg.sv | 46 ++++
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared opcode/funct constants, FSM state encoding and ALU operation classes
// for the multicycle MIPS-style controller.
package cpu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_JR     = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // States that stall on the unified memory and are covered by the wait timer
    function automatic logic is_mem_wait(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory handshake between the controller (master) and memory (slave).
interface multicycle_ctrl_if;
    logic mem_read_o;
    logic mem_write_o;
    logic iord_o;
    logic mem_ready_i;

    modport master (output mem_read_o, output mem_write_o, output iord_o, input mem_ready_i);
    modport slave  (input mem_read_o, input mem_write_o, input iord_o, output mem_ready_i);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of a memory wait and flags the cycle whose stall
// would bring the count to MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    input  logic ready,
    output logic expired
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (waiting && !ready)
            count <= count + 1'b1;
    end

    // A ready in this cycle completes the access, so it never times out
    assign expired = waiting && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with memory
// wait timeout and sticky error reporting.
module multicycle_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    input  logic               cond_i,
    multicycle_ctrl_if.master  mem,
    output logic               pc_write_o,
    output logic               ir_write_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_op_o,
    output logic [1:0]         pc_src_o,
    output logic [3:0]         state_o,
    output logic               done_o,
    output logic [1:0]         err_o
);
    state_e     state_q, state_n;
    logic [1:0] err_q, err_set;
    logic       timeout, timer_clear;
    logic       mem_read, mem_write, iord;

    assign timer_clear = is_mem_wait(state_n) && (state_n != state_q);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .waiting (is_mem_wait(state_q)),
        .ready   (mem.mem_ready_i),
        .expired (timeout)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_n;
            if (err_q == ERR_NONE)
                err_q <= err_set;
        end
    end

    always_comb begin
        state_n      = state_q;
        err_set      = ERR_NONE;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = ALU_ADD;
        pc_src_o     = 2'd0;
        done_o       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b_o = 2'd1;
                if (mem.mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_n    = S_DECODE;
                end else if (timeout) begin
                    state_n = S_HALT;
                    err_set = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                case (op_i)
                    OP_RTYPE:         state_n = (funct_i == FN_JR) ? S_JR : S_RTEX;
                    OP_LW, OP_SW:     state_n = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_n = S_IMMEX;
                    OP_BEQ, OP_BNE:   state_n = S_BRANCH;
                    OP_J, OP_JAL:     state_n = S_JUMP;
                    default: begin
                        state_n = S_HALT;
                        err_set = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                state_n     = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem.mem_ready_i) begin
                    state_n = S_MEMWB;
                end else if (timeout) begin
                    state_n = S_HALT;
                    err_set = ERR_TIMEOUT;
                end
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
                done_o       = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem.mem_ready_i) begin
                    done_o  = 1'b1;
                    state_n = S_FETCH;
                end else if (timeout) begin
                    state_n = S_HALT;
                    err_set = ERR_TIMEOUT;
                end
            end
            S_RTEX: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_RTYPE;
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (op_i == OP_RTYPE) ? 2'd1 : 2'd0;
                done_o      = 1'b1;
                state_n     = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_n     = S_ALUWB;
            end
            S_BRANCH: begin
                // cond_i already folds in the bne inversion in the datapath
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_write_o  = cond_i;
                pc_src_o    = cond_i ? 2'd1 : 2'd0;
                done_o      = 1'b1;
                state_n     = S_FETCH;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd2;
                if (op_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'd2;
                    mem_to_reg_o = 2'd2;
                end
                done_o  = 1'b1;
                state_n = S_FETCH;
            end
            S_JR: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd3;
                done_o     = 1'b1;
                state_n    = S_FETCH;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_HALT;
        endcase

        // Reset parks the FSM in FETCH; keep its Moore strobes quiet meanwhile
        if (!rst_n) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            pc_write_o  = 1'b0;
            ir_write_o  = 1'b0;
            reg_write_o = 1'b0;
            done_o      = 1'b0;
        end
    end

    assign mem.mem_read_o  = mem_read;
    assign mem.mem_write_o = mem_write;
    assign mem.iord_o      = iord;
    assign state_o         = state_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: instruction classes,
// memory waits, timeout boundary, illegal opcode and async reset.
module tb_multicycle_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_n;
    logic [5:0] op_i, funct_i;
    logic       cond_i;
    logic       pc_write_o, ir_write_o, reg_write_o, alu_src_a_o, done_o;
    logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o, err_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
    int         total = 0;
    int         bad = 0;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .cond_i       (cond_i),
        .mem          (mif.master),
        .pc_write_o   (pc_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_src_o     (pc_src_o),
        .state_o      (state_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        mif.mem_ready_i = 1'b0;
        rst_n = 1'b0;
        #2;
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Completes FETCH immediately and leaves the bench in the DECODE cycle
    task automatic fetch_op(input logic [5:0] op, input logic [5:0] fn);
        op_i = op;
        funct_i = fn;
        mif.mem_ready_i = 1'b1;
        #1;
        check_eq("fetch_state", state_o, 0);
        check_eq("fetch_irw", ir_write_o, 1);
        check_eq("fetch_pcw", pc_write_o, 1);
        nxt();
        mif.mem_ready_i = 1'b0;
        #1;
        check_eq("decode_state", state_o, 1);
        check_eq("decode_srcb", alu_src_b_o, 3);
    endtask

    initial begin
        int rd_cycles;
        op_i = '0;
        funct_i = '0;
        cond_i = 1'b0;
        mif.mem_ready_i = 1'b0;
        rst_n = 1'b0;
        #3;
        check_eq("rst_state", state_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_memrd", mif.mem_read_o, 0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("first_memrd", mif.mem_read_o, 1);
        check_eq("first_iord", mif.iord_o, 0);
        check_eq("first_srcb", alu_src_b_o, 1);
        check_eq("first_irw_wait", ir_write_o, 0);

        // R-type add
        fetch_op(6'h00, 6'h20);
        nxt();
        check_eq("rtex_state", state_o, 6);
        check_eq("rtex_srca", alu_src_a_o, 1);
        check_eq("rtex_aluop", alu_op_o, 2);
        nxt();
        check_eq("aluwb_state", state_o, 7);
        check_eq("aluwb_regw", reg_write_o, 1);
        check_eq("aluwb_dst", reg_dst_o, 1);
        check_eq("aluwb_done", done_o, 1);
        nxt();
        check_eq("ret_state", state_o, 0);
        check_eq("ret_done", done_o, 0);

        // lw with three not-ready cycles in MEMRD
        fetch_op(6'h23, 6'h00);
        nxt();
        check_eq("memadr_state", state_o, 2);
        check_eq("memadr_srcb", alu_src_b_o, 2);
        rd_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            mif.mem_ready_i = (i == 3);
            #1;
            if (mif.mem_read_o === 1'b1 && mif.iord_o === 1'b1 && state_o === 4'd3)
                rd_cycles++;
        end
        check_eq("memrd_cycles", rd_cycles, 4);
        nxt();
        mif.mem_ready_i = 1'b0;
        #1;
        check_eq("memwb_state", state_o, 4);
        check_eq("memwb_m2r", mem_to_reg_o, 1);
        check_eq("memwb_regw", reg_write_o, 1);
        check_eq("memwb_dst", reg_dst_o, 0);
        nxt();

        // beq not taken / taken
        for (int c = 0; c < 2; c++) begin
            fetch_op(6'h04, 6'h00);
            cond_i = (c == 1);
            nxt();
            check_eq("br_state", state_o, 8);
            check_eq("br_pcw", pc_write_o, c);
            check_eq("br_pcsrc", pc_src_o, c);
            check_eq("br_done", done_o, 1);
            nxt();
            cond_i = 1'b0;
        end

        // jal
        fetch_op(6'h03, 6'h00);
        nxt();
        check_eq("jal_state", state_o, 9);
        check_eq("jal_pcw", pc_write_o, 1);
        check_eq("jal_pcsrc", pc_src_o, 2);
        check_eq("jal_regw", reg_write_o, 1);
        check_eq("jal_dst", reg_dst_o, 2);
        check_eq("jal_m2r", mem_to_reg_o, 2);
        nxt();

        // jr
        fetch_op(6'h00, 6'h08);
        nxt();
        check_eq("jr_state", state_o, 11);
        check_eq("jr_pcsrc", pc_src_o, 3);
        nxt();

        // slti -> IMMEX -> ALUWB with rt destination
        fetch_op(6'h0A, 6'h00);
        nxt();
        check_eq("immex_state", state_o, 10);
        check_eq("immex_srcb", alu_src_b_o, 2);
        check_eq("immex_aluop", alu_op_o, 3);
        nxt();
        check_eq("immwb_dst", reg_dst_o, 0);
        check_eq("immwb_regw", reg_write_o, 1);
        nxt();

        // sw, then async reset in the middle of the MEMWR wait
        fetch_op(6'h2B, 6'h00);
        nxt();
        nxt();
        check_eq("memwr_state", state_o, 5);
        check_eq("memwr_wr", mif.mem_write_o, 1);
        check_eq("memwr_iord", mif.iord_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_wr", mif.mem_write_o, 0);
        check_eq("rst_mid_rd", mif.mem_read_o, 0);
        check_eq("rst_mid_state", state_o, 0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("rel_state", state_o, 0);
        check_eq("rel_memrd", mif.mem_read_o, 1);

        // illegal opcode
        fetch_op(6'h3F, 6'h00);
        nxt();
        check_eq("ill_state", state_o, 15);
        check_eq("ill_err", err_o, 1);
        mif.mem_ready_i = 1'b1;
        nxt();
        nxt();
        check_eq("halt_stays", state_o, 15);
        check_eq("halt_memrd", mif.mem_read_o, 0);
        check_eq("halt_err_keep", err_o, 1);

        // FETCH timeout: 15 not-ready cycles
        apply_reset();
        for (int i = 0; i < 14; i++) nxt();
        check_eq("to_cycle15_state", state_o, 0);
        nxt();
        check_eq("to_state", state_o, 15);
        check_eq("to_err", err_o, 2);
        check_eq("to_irw", ir_write_o, 0);

        // ready arriving in the 15th cycle completes the fetch
        apply_reset();
        for (int i = 0; i < 14; i++) nxt();
        mif.mem_ready_i = 1'b1;
        #1;
        check_eq("edge_irw", ir_write_o, 1);
        nxt();
        mif.mem_ready_i = 1'b0;
        #1;
        check_eq("edge_state", state_o, 1);
        check_eq("edge_err", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
